// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the round-robin source-to-destination FIFO arbiter.
package arbitro_rr_pkg;

  localparam int NUM_FIFO = 4;
  localparam int PTR_W    = 2;

  // The destination field sits in the top bits of each word, counted down from the MSB.
  localparam int DEST_MSB_OFS = 1;
  localparam int DEST_LSB_OFS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_FIFO-1:0] idx_to_onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_FIFO-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/arbitro_rr_priority_select.sv
// Combinational rotating-priority picker: first requester at or above ptr, wrapping.
module rr_priority_select
  import arbitro_rr_pkg::*;
(
  input  logic [NUM_FIFO-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_FIFO-1:0] grant,
  output logic [PTR_W-1:0]    grant_idx
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the closest requester overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_FIFO - 1; k >= 0; k--) begin
      cand = ptr + PTR_W'(k);
      if (req[cand]) begin
        grant     = idx_to_onehot(cand);
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter draining four source FIFOs into four destination FIFOs,
// routing each word by its two MSBs; popping halts while any destination is almost full.
module arbitro_rr
  import arbitro_rr_pkg::*;
#(
  parameter int WORD_SIZE = 6
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [NUM_FIFO-1:0]           fifo_empty,
  input  logic [NUM_FIFO*WORD_SIZE-1:0] fifo_data_out,
  input  logic [NUM_FIFO-1:0]           dest_almost_full,
  output logic [NUM_FIFO-1:0]           fifo_rd,
  output logic [NUM_FIFO-1:0]           fifo_wr,
  output logic [WORD_SIZE-1:0]          fifo_data_in,
  output logic [1:0]                    arb_state
);

  localparam int DEST_MSB = WORD_SIZE - DEST_MSB_OFS;
  localparam int DEST_LSB = WORD_SIZE - DEST_LSB_OFS;

  arb_state_t           state;
  logic                 pause;
  logic                 any_req;
  logic                 pop_now;
  logic                 pop_q;
  logic [NUM_FIFO-1:0]  req;
  logic [NUM_FIFO-1:0]  grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     src_q;
  logic [WORD_SIZE-1:0] src_word;

  assign pause   = |dest_almost_full;
  assign req     = ~fifo_empty;
  assign any_req = |req;

  rr_priority_select u_select (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The pop strobe follows the live inputs so a freshly non-empty source is served the same cycle.
  assign pop_now = (|grant) && !pause && reset_L;
  assign fifo_rd = pop_now ? grant : '0;

  always_comb begin
    src_word = '0;
    for (int i = 0; i < NUM_FIFO; i++) begin
      if (src_q == PTR_W'(i)) begin
        src_word = fifo_data_out[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // State, pointer and the two-stage pop->push pipeline; the source presents the
  // popped word one cycle after the pop, so it is captured on the following edge.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      pop_q        <= 1'b0;
      src_q        <= '0;
      fifo_wr      <= '0;
      fifo_data_in <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACTIVE, ST_PAUSE: begin
          if (pause) begin
            state <= ST_PAUSE;
          end else if (any_req) begin
            state <= ST_ACTIVE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (pop_now) begin
        rr_ptr <= grant_idx + PTR_W'(1);
      end
      pop_q <= pop_now;
      src_q <= grant_idx;

      if (pop_q) begin
        fifo_data_in <= src_word;
        fifo_wr      <= idx_to_onehot(src_word[DEST_MSB:DEST_LSB]);
      end else begin
        fifo_wr <= '0;
      end
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr with a behavioural registered-read source FIFO bank.
module tb_arbitro_rr;

  localparam int WS = 6;

  logic          clk;
  logic          reset_L;
  logic [3:0]    fifo_empty;
  logic [4*WS-1:0] fifo_data_out;
  logic [3:0]    dest_almost_full;
  logic [3:0]    fifo_rd;
  logic [3:0]    fifo_wr;
  logic [WS-1:0] fifo_data_in;
  logic [1:0]    arb_state;

  int total = 0;
  int bad   = 0;

  logic [WS-1:0] src_mem [4][64];
  int            wp [4] = '{default: 0};
  int            rp [4] = '{default: 0};
  logic [WS-1:0] src_dout [4] = '{default: '0};
  logic          flush = 1'b0;

  logic [3:0]    rot_rd   [11] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
  logic [3:0]    rot_wr   [11] = '{4'h0, 4'h0, 4'h8, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
  logic [WS-1:0] rot_data [11] = '{6'h00, 6'h00, 6'h30, 6'h01, 6'h12, 6'h23, 6'h04, 6'h15, 6'h26, 6'h37, 6'h37};
  logic [1:0]    rot_st   [11] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};

  arbitro_rr #(.WORD_SIZE(WS)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .fifo_empty       (fifo_empty),
    .fifo_data_out    (fifo_data_out),
    .dest_almost_full (dest_almost_full),
    .fifo_rd          (fifo_rd),
    .fifo_wr          (fifo_wr),
    .fifo_data_in     (fifo_data_in),
    .arb_state        (arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO model: read data and empty flag both change on the edge that ends the pop cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush) begin
        rp[i] <= wp[i];
      end else if (fifo_rd[i] && (rp[i] != wp[i])) begin
        src_dout[i] <= src_mem[i][rp[i]];
        rp[i]       <= rp[i] + 1;
      end
    end
  end

  always_comb begin
    fifo_empty    = '0;
    fifo_data_out = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]           = (rp[i] == wp[i]);
      fifo_data_out[i*WS +: WS] = src_dout[i];
    end
  end

  task automatic pushWord(input int s, input logic [WS-1:0] w);
    src_mem[s][wp[s]] = w;
    wp[s] = wp[s] + 1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [3:0] afull);
    reset_L          = rst_n;
    dest_almost_full = afull;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_rd, input logic [3:0] e_wr,
                             input logic [WS-1:0] e_data, input logic [1:0] e_st);
    total++;
    assert (fifo_rd === e_rd) else begin
      bad++;
      $error("[TB] FAIL %s fifo_rd got %b want %b", tag, fifo_rd, e_rd);
    end
    total++;
    assert (fifo_wr === e_wr) else begin
      bad++;
      $error("[TB] FAIL %s fifo_wr got %b want %b", tag, fifo_wr, e_wr);
    end
    total++;
    assert (fifo_data_in === e_data) else begin
      bad++;
      $error("[TB] FAIL %s fifo_data_in got %h want %h", tag, fifo_data_in, e_data);
    end
    total++;
    assert (arb_state === e_st) else begin
      bad++;
      $error("[TB] FAIL %s arb_state got %0d want %0d", tag, arb_state, e_st);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    applyStimulus(1'b0, 4'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b1, 4'h0);
  endtask

  initial begin
    applyStimulus(1'b0, 4'h0);

    $display("[TB] reset with all sources non-empty");
    @(negedge clk);
    pushWord(0, 6'h3F); pushWord(1, 6'h15); pushWord(2, 6'h2A); pushWord(3, 6'h07);
    #1 checkOutput("reset0", 4'h0, 4'h0, 6'h00, 2'd0);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk); #1 checkOutput("reset_hold", 4'h0, 4'h0, 6'h00, 2'd0);
    end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; applyStimulus(1'b1, 4'h0);

    $display("[TB] single source");
    @(negedge clk);
    pushWord(0, 6'h25); pushWord(0, 6'h0A); pushWord(0, 6'h3F);
    #1 checkOutput("single0", 4'h1, 4'h0, 6'h00, 2'd0);
    @(negedge clk); #1 checkOutput("single1", 4'h1, 4'h0, 6'h00, 2'd1);
    @(negedge clk); #1 checkOutput("single2", 4'h1, 4'h4, 6'h25, 2'd1);
    @(negedge clk); #1 checkOutput("single3", 4'h0, 4'h1, 6'h0A, 2'd1);
    @(negedge clk); #1 checkOutput("single4", 4'h0, 4'h8, 6'h3F, 2'd0);
    @(negedge clk); #1 checkOutput("single5", 4'h0, 4'h0, 6'h3F, 2'd0);

    $display("[TB] rotation");
    resetDut();
    @(negedge clk);
    pushWord(0, 6'h30); pushWord(1, 6'h01); pushWord(2, 6'h12); pushWord(3, 6'h23);
    pushWord(0, 6'h04); pushWord(1, 6'h15); pushWord(2, 6'h26); pushWord(3, 6'h37);
    #1 checkOutput("rot", rot_rd[0], rot_wr[0], rot_data[0], rot_st[0]);
    for (int k = 1; k < 11; k++) begin
      @(negedge clk); #1 checkOutput($sformatf("rot%0d", k), rot_rd[k], rot_wr[k], rot_data[k], rot_st[k]);
    end

    $display("[TB] pause");
    resetDut();
    @(negedge clk);
    pushWord(0, 6'h05); pushWord(0, 6'h27); pushWord(1, 6'h16); pushWord(1, 6'h38);
    #1 checkOutput("pause0", 4'h1, 4'h0, 6'h00, 2'd0);
    @(negedge clk); applyStimulus(1'b1, 4'h4);
    #1 checkOutput("pause1", 4'h0, 4'h0, 6'h00, 2'd1);
    @(negedge clk); #1 checkOutput("pause2", 4'h0, 4'h1, 6'h05, 2'd2);
    @(negedge clk); #1 checkOutput("pause3", 4'h0, 4'h0, 6'h05, 2'd2);
    @(negedge clk); applyStimulus(1'b1, 4'h0);
    #1 checkOutput("resume0", 4'h2, 4'h0, 6'h05, 2'd2);
    @(negedge clk); #1 checkOutput("resume1", 4'h1, 4'h0, 6'h05, 2'd1);
    @(negedge clk); #1 checkOutput("resume2", 4'h2, 4'h2, 6'h16, 2'd1);
    @(negedge clk); #1 checkOutput("resume3", 4'h0, 4'h4, 6'h27, 2'd1);
    @(negedge clk); #1 checkOutput("resume4", 4'h0, 4'h8, 6'h38, 2'd0);

    $display("[TB] reset mid-stream");
    @(negedge clk);
    pushWord(0, 6'h11); pushWord(0, 6'h22); pushWord(0, 6'h33);
    #1 checkOutput("mid0", 4'h1, 4'h0, 6'h38, 2'd0);
    @(negedge clk); #1 checkOutput("mid1", 4'h1, 4'h0, 6'h38, 2'd1);
    @(negedge clk); #1 checkOutput("mid2", 4'h1, 4'h2, 6'h11, 2'd1);
    #2 applyStimulus(1'b0, 4'h0);
    #1 checkOutput("mid_async", 4'h0, 4'h0, 6'h00, 2'd0);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; applyStimulus(1'b1, 4'h0);
    #1 checkOutput("mid_rel0", 4'h0, 4'h0, 6'h00, 2'd0);
    @(negedge clk); #1 checkOutput("mid_rel1", 4'h0, 4'h0, 6'h00, 2'd0);
    @(negedge clk); #1 checkOutput("mid_rel2", 4'h0, 4'h0, 6'h00, 2'd0);

    $display("[TB] pointer wrap");
    resetDut();
    @(negedge clk);
    pushWord(2, 6'h02);
    #1 checkOutput("wrap0", 4'h4, 4'h0, 6'h00, 2'd0);
    @(negedge clk);
    pushWord(3, 6'h33); pushWord(0, 6'h20);
    #1 checkOutput("wrap1", 4'h8, 4'h0, 6'h00, 2'd1);
    @(negedge clk); #1 checkOutput("wrap2", 4'h1, 4'h1, 6'h02, 2'd1);
    @(negedge clk); #1 checkOutput("wrap3", 4'h0, 4'h8, 6'h33, 2'd1);
    @(negedge clk); #1 checkOutput("wrap4", 4'h0, 4'h4, 6'h20, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
